// File: rtl/cache_bus_arbiter.sv
// Two-master pipelined Wishbone arbiter: I-cache refill (A) and D-cache refill/write-back (B)
// share one memory bus, with per-cycle ownership, round-robin ties, outstanding tracking and a watchdog.
module cache_bus_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int LGOUT     = 4,
    parameter int LGTIMEOUT = 10
) (
    input  logic            i_clk,
    input  logic            i_reset,
    // master A (instruction-cache refill)
    input  logic            i_a_cyc,
    input  logic            i_a_stb,
    input  logic            i_a_we,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic [DW/8-1:0] i_a_sel,
    output logic            o_a_stall,
    output logic            o_a_ack,
    output logic            o_a_err,
    output logic [DW-1:0]   o_a_data,
    // master B (data-cache refill / write-back)
    input  logic            i_b_cyc,
    input  logic            i_b_stb,
    input  logic            i_b_we,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    input  logic [DW/8-1:0] i_b_sel,
    output logic            o_b_stall,
    output logic            o_b_ack,
    output logic            o_b_err,
    output logic [DW-1:0]   o_b_data,
    // memory side
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic            i_wb_err,
    input  logic [DW-1:0]   i_wb_data,
    output logic [1:0]      o_grant,
    output logic [1:0]      dbg_state
);

    // Handshake: a request transfers on a cycle where o_wb_stb is high and i_wb_stall is low;
    // a master's request transfers when its stb is high and its stall is low. Each ack/err
    // answers exactly one earlier transfer, in order.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        ABORT = 2'd3
    } state_t;

    // Fires one cycle before the counter would reach 2^LGTIMEOUT-1, so the error lands
    // exactly 2^LGTIMEOUT-1 cycles after the last accept or ack.
    localparam logic [LGTIMEOUT-1:0] WD_FIRE = {{(LGTIMEOUT-1){1'b1}}, 1'b0};

    state_t               state, state_nx;
    logic                 abort_b, abort_b_nx;
    logic                 last_b, last_b_nx;
    logic [LGOUT-1:0]     outs;
    logic [LGTIMEOUT-1:0] wd;

    logic own_a, own_b, in_abort, owned;
    logic full, x_cyc, x_stb, accept, ack_in, err_in;
    logic wd_count, wd_fire, release_now, enter_abort, abort_cyc;

    // Outputs are forced to their idle values while reset is held.
    assign own_a    = (state == OWN_A) & ~i_reset;
    assign own_b    = (state == OWN_B) & ~i_reset;
    assign in_abort = (state == ABORT) & ~i_reset;
    assign owned    = own_a | own_b;
    assign full     = &outs;

    assign x_cyc = own_b ? i_b_cyc : i_a_cyc;
    assign x_stb = own_b ? i_b_stb : i_a_stb;

    assign o_wb_cyc  = owned & x_cyc;
    assign o_wb_stb  = owned & x_cyc & x_stb & ~full;
    assign o_wb_we   = own_b ? i_b_we   : i_a_we;
    assign o_wb_addr = own_b ? i_b_addr : i_a_addr;
    assign o_wb_data = own_b ? i_b_data : i_a_data;
    assign o_wb_sel  = own_b ? i_b_sel  : i_a_sel;

    assign accept   = o_wb_stb & ~i_wb_stall;
    assign ack_in   = owned & i_wb_ack;
    assign err_in   = owned & i_wb_err;
    assign wd_count = owned & (outs != '0) & ~i_wb_ack & ~i_wb_err;
    assign wd_fire  = wd_count & (wd == WD_FIRE);

    assign o_a_stall = ~own_a | i_wb_stall | full;
    assign o_a_ack   = own_a & i_wb_ack;
    assign o_a_err   = own_a & (i_wb_err | wd_fire);
    assign o_a_data  = i_wb_data;

    assign o_b_stall = ~own_b | i_wb_stall | full;
    assign o_b_ack   = own_b & i_wb_ack;
    assign o_b_err   = own_b & (i_wb_err | wd_fire);
    assign o_b_data  = i_wb_data;

    assign o_grant   = {own_b | (in_abort & abort_b), own_a | (in_abort & ~abort_b)};
    assign dbg_state = state;
    assign abort_cyc = abort_b ? i_b_cyc : i_a_cyc;

    always_comb begin
        state_nx    = state;
        abort_b_nx  = abort_b;
        last_b_nx   = last_b;
        release_now = 1'b0;
        enter_abort = 1'b0;
        case (state)
            IDLE: begin
                if (i_a_cyc && (!i_b_cyc || last_b)) state_nx = OWN_A;
                else if (i_b_cyc)                    state_nx = OWN_B;
            end
            OWN_A: begin
                if (!i_a_cyc) begin
                    release_now = 1'b1;
                    last_b_nx   = 1'b0;
                    state_nx    = i_b_cyc ? OWN_B : IDLE;
                end else if (wd_fire) begin
                    enter_abort = 1'b1;
                    abort_b_nx  = 1'b0;
                    state_nx    = ABORT;
                end
            end
            OWN_B: begin
                if (!i_b_cyc) begin
                    release_now = 1'b1;
                    last_b_nx   = 1'b1;
                    state_nx    = i_a_cyc ? OWN_A : IDLE;
                end else if (wd_fire) begin
                    enter_abort = 1'b1;
                    abort_b_nx  = 1'b1;
                    state_nx    = ABORT;
                end
            end
            ABORT: begin
                if (!abort_cyc) begin
                    release_now = 1'b1;
                    last_b_nx   = abort_b;
                    if (abort_b) state_nx = i_a_cyc ? OWN_A : IDLE;
                    else         state_nx = i_b_cyc ? OWN_B : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            abort_b <= 1'b0;
            last_b  <= 1'b1;
            outs    <= '0;
            wd      <= '0;
        end else begin
            state   <= state_nx;
            abort_b <= abort_b_nx;
            last_b  <= last_b_nx;

            if (release_now || enter_abort || err_in || !owned)
                outs <= '0;
            else if (accept && !ack_in)
                outs <= outs + 1'b1;
            else if (!accept && ack_in && outs != '0)
                outs <= outs - 1'b1;

            if (release_now || enter_abort || !wd_count)
                wd <= '0;
            else
                wd <= wd + 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: a scripted memory model, an expected-request queue and
// per-master expected-response queues checked by a negedge monitor.
module tb_cache_bus_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int LGOUT     = 2;
    localparam int LGTIMEOUT = 4;
    localparam int RW        = 1 + DW/8 + AW + DW;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } pend_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic            a_cyc = 0, a_stb = 0, a_we = 0;
    logic [AW-1:0]   a_addr = '0;
    logic [DW-1:0]   a_data = '0;
    logic [DW/8-1:0] a_sel = '0;
    logic            b_cyc = 0, b_stb = 0, b_we = 0;
    logic [AW-1:0]   b_addr = '0;
    logic [DW-1:0]   b_data = '0;
    logic [DW/8-1:0] b_sel = '0;
    logic            wb_stall = 0, wb_ack = 0, wb_err = 0;
    logic [DW-1:0]   wb_rdata = '0;

    logic            o_a_stall, o_a_ack, o_a_err, o_b_stall, o_b_ack, o_b_err;
    logic [DW-1:0]   o_a_data, o_b_data, o_wb_data;
    logic            o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0]   o_wb_addr;
    logic [DW/8-1:0] o_wb_sel;
    logic [1:0]      o_grant, dbg_state;

    cache_bus_arbiter #(.AW(AW), .DW(DW), .LGOUT(LGOUT), .LGTIMEOUT(LGTIMEOUT)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
        .i_a_data(a_data), .i_a_sel(a_sel),
        .o_a_stall(o_a_stall), .o_a_ack(o_a_ack), .o_a_err(o_a_err), .o_a_data(o_a_data),
        .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
        .i_b_data(b_data), .i_b_sel(b_sel),
        .o_b_stall(o_b_stall), .o_b_ack(o_b_ack), .o_b_err(o_b_err), .o_b_data(o_b_data),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
        .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_rdata),
        .o_grant(o_grant), .dbg_state(dbg_state)
    );

    // ---------------- clock / global bound ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard state ----------------
    logic [RW-1:0] exp_req_q[$];
    logic [DW-1:0] exp_a_q[$];
    logic [DW-1:0] exp_b_q[$];
    pend_t         pend_q[$];

    int cyc_n = 0;
    int mem_lat = 2;
    bit stall_toggle = 0;
    bit mem_manual = 0;
    bit mem_drop = 0;
    int manual_req = 0;
    int manual_done = 0;

    int a_ack_n = 0, b_ack_n = 0, a_err_n = 0, b_err_n = 0;
    int wb_acc_n = 0, last_acc_cyc = 0, last_b_ack_cyc = 0;
    bit watch_a_blocked = 0;
    int a_viol = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] req(input logic we, input logic [DW/8-1:0] sel,
                                          input logic [AW-1:0] addr, input logic [DW-1:0] data);
        return {we, sel, addr, we ? data : {DW{1'b0}}};
    endfunction

    // ---------------- memory model ----------------
    initial begin
        forever begin
            @(posedge clk); #1;
            cyc_n++;
            wb_ack   = 1'b0;
            wb_err   = 1'b0;
            wb_rdata = '0;
            wb_stall = stall_toggle ? cyc_n[0] : 1'b0;
            if (pend_q.size() > 0) begin
                if (mem_manual ? (manual_req > manual_done) : (pend_q[0].due <= cyc_n)) begin
                    wb_ack   = 1'b1;
                    wb_rdata = pend_q[0].data;
                    void'(pend_q.pop_front());
                    if (mem_manual) manual_done++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        pend_t p;
        logic [RW-1:0] e;
        if (o_wb_cyc && o_wb_stb && !wb_stall) begin
            wb_acc_n++;
            last_acc_cyc = cyc_n;
            if (exp_req_q.size() == 0) begin
                check("wb_req_unexpected", {o_wb_we, o_wb_addr}, 0);
            end else begin
                e = exp_req_q.pop_front();
                check("wb_req", req(o_wb_we, o_wb_sel, o_wb_addr, o_wb_data), e);
            end
            if (!mem_drop) begin
                p.due  = cyc_n + mem_lat;
                p.data = o_wb_we ? '0 : (32'hDEADBEEF + o_wb_addr - 32'h100);
                pend_q.push_back(p);
            end
        end
        if (o_a_ack) begin
            a_ack_n++;
            if (exp_a_q.size() == 0) check("a_ack_unexpected", {1'b1, o_a_data}, 0);
            else                     check("a_ack_data", o_a_data, exp_a_q.pop_front());
        end
        if (o_b_ack) begin
            b_ack_n++;
            last_b_ack_cyc = cyc_n;
            if (exp_b_q.size() == 0) check("b_ack_unexpected", {1'b1, o_b_data}, 0);
            else                     check("b_ack_data", o_b_data, exp_b_q.pop_front());
        end
        if (o_a_err) a_err_n++;
        if (o_b_err) b_err_n++;
        if (watch_a_blocked && (o_a_stall !== 1'b1 || o_a_ack !== 1'b0)) a_viol++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue_a(input logic we, input logic [DW/8-1:0] sel,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bit acc = 0;
        int g = 0;
        a_stb = 1; a_we = we; a_sel = sel; a_addr = addr; a_data = data;
        while (!acc && g < 50) begin
            @(negedge clk);
            acc = !o_a_stall;
            tick();
            g++;
        end
        if (!acc) check("a_accept_timeout", 0, 1);
        a_stb = 0;
    endtask

    task automatic issue_b(input logic we, input logic [DW/8-1:0] sel,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bit acc = 0;
        int g = 0;
        b_stb = 1; b_we = we; b_sel = sel; b_addr = addr; b_data = data;
        while (!acc && g < 50) begin
            @(negedge clk);
            acc = !o_b_stall;
            tick();
            g++;
        end
        if (!acc) check("b_accept_timeout", 0, 1);
        b_stb = 0;
    endtask

    task automatic wait_acks(input string name, input int a_target, input int b_target);
        int g = 0;
        while ((a_ack_n < a_target || b_ack_n < b_target) && g < 100) begin
            tick();
            g++;
        end
        check(name, (a_ack_n >= a_target) && (b_ack_n >= b_target), 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int a0, b0, acc0, e0, err_cyc, g;
        bit seen;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_grant", o_grant, 2'b00);
        check("rst_wb_cyc_stb", {o_wb_cyc, o_wb_stb}, 2'b00);
        check("rst_stalls", {o_a_stall, o_b_stall}, 2'b11);
        check("rst_resp", {o_a_ack, o_a_err, o_b_ack, o_b_err}, 4'b0000);
        tick(); rst = 0;
        @(negedge clk);
        check("post_rst_grant", o_grant, 2'b00);
        check("post_rst_stalls", {o_a_stall, o_b_stall}, 2'b11);

        // first tie goes to A; A single read of 0x100
        exp_req_q.push_back(req(0, 4'hF, 32'h100, 0));
        exp_a_q.push_back(32'hDEADBEEF);
        tick();
        a_cyc = 1; a_stb = 1; a_we = 0; a_sel = 4'hF; a_addr = 32'h100;
        b_cyc = 1;
        @(negedge clk);
        check("arb_wait_a_stall", o_a_stall, 1);
        check("arb_wait_grant", o_grant, 2'b00);
        tick();
        @(negedge clk);
        check("tie1_grant", o_grant, 2'b01);
        check("tie1_wb_stb_addr", {o_wb_stb, o_wb_addr}, {1'b1, 32'h100});
        check("tie1_b_stall", o_b_stall, 1);
        tick(); a_stb = 0;
        wait_acks("tie1_a_ack", 1, 0);

        // handover to B with no idle gap
        a_cyc = 0;
        @(negedge clk);
        check("handover_wb_cyc", o_wb_cyc, 0);
        tick();
        @(negedge clk);
        check("handover_grant", o_grant, 2'b10);
        exp_req_q.push_back(req(0, 4'hF, 32'h104, 0));
        exp_b_q.push_back(32'hDEADBEF3);
        tick();
        issue_b(0, 4'hF, 32'h104, 0);
        wait_acks("b_read_ack", 1, 1);
        b_cyc = 0;

        // second tie after B released (last = B) goes to A
        tick(); a_cyc = 1; b_cyc = 1;
        tick();
        @(negedge clk);
        check("tie2_grant", o_grant, 2'b01);
        tick(); a_cyc = 0; b_cyc = 0;
        tick();
        @(negedge clk);
        check("tie2_idle", o_grant, 2'b00);

        // third tie (last = A) goes to B; 8 pipelined writes, A held requesting
        mem_lat = 1;
        stall_toggle = 1;
        for (int i = 0; i < 8; i++) begin
            exp_req_q.push_back(req(1, 4'h3, 32'h1000 + 4 * i, 32'h11110000 + i));
            exp_b_q.push_back(32'h0);
        end
        exp_req_q.push_back(req(0, 4'hF, 32'h200, 0));
        exp_a_q.push_back(32'hDEADBFEF);
        tick();
        a_cyc = 1; a_stb = 1; a_we = 0; a_sel = 4'hF; a_addr = 32'h200;
        b_cyc = 1;
        tick();
        @(negedge clk);
        check("tie3_grant", o_grant, 2'b10);
        tick();
        watch_a_blocked = 1;
        a0 = a_ack_n; b0 = b_ack_n; acc0 = wb_acc_n;
        for (int i = 0; i < 8; i++) issue_b(1, 4'h3, 32'h1000 + 4 * i, 32'h11110000 + i);
        wait_acks("burst_b_acks_done", a0, b0 + 8);
        check("burst_accepts", wb_acc_n - acc0, 8);
        watch_a_blocked = 0;
        b_cyc = 0;
        check("a_blocked_during_b", a_viol, 0);
        check("a_acks_during_b", a_ack_n - a0, 0);
        issue_a(0, 4'hF, 32'h200, 0);
        wait_acks("a_after_burst_ack", a0 + 1, b0 + 8);
        check("burst_b_ack_count", b_ack_n - b0, 8);
        a_cyc = 0;
        stall_toggle = 0;

        // outstanding limit: 3 unacked, 4th held until one ack
        tick();
        mem_lat = 2;
        manual_req = manual_done;
        mem_manual = 1;
        b_cyc = 1;
        for (int i = 0; i < 4; i++) begin
            exp_req_q.push_back(req(0, 4'hF, 32'h300 + 4 * i, 0));
            exp_b_q.push_back(32'hDEADC0EF + 4 * i);
        end
        b0 = b_ack_n;
        for (int i = 0; i < 3; i++) issue_b(0, 4'hF, 32'h300 + 4 * i, 0);
        b_stb = 1; b_addr = 32'h30C;
        @(negedge clk);
        check("full_stb_blocked", {o_wb_stb, o_b_stall}, 2'b01);
        tick();
        @(negedge clk);
        check("full_stb_blocked2", {o_wb_stb, o_b_stall}, 2'b01);
        tick();
        manual_req = manual_req + 1;
        issue_b(0, 4'hF, 32'h30C, 0);
        check("full_accept_after_ack", last_acc_cyc - last_b_ack_cyc, 1);
        manual_req = manual_req + 3;
        wait_acks("full_all_acks", a_ack_n, b0 + 4);
        b_cyc = 0;
        mem_manual = 0;

        // watchdog: accepted write never acked
        tick();
        mem_drop = 1;
        b_cyc = 1;
        e0 = b_err_n;
        exp_req_q.push_back(req(1, 4'hF, 32'h400, 32'hCAFEF00D));
        issue_b(1, 4'hF, 32'h400, 32'hCAFEF00D);
        seen = 0; g = 0; err_cyc = 0;
        while (!seen && g < 40) begin
            @(negedge clk);
            if (o_b_err) begin
                seen = 1;
                err_cyc = cyc_n;
            end
            g++;
        end
        check("wd_fired", seen, 1);
        check("wd_latency", err_cyc - last_acc_cyc, 15);
        @(negedge clk);
        check("wd_single_pulse", o_b_err, 0);
        check("abort_wb_cyc_stb", {o_wb_cyc, o_wb_stb}, 2'b00);
        check("abort_grant", o_grant, 2'b10);
        check("abort_stall_ack", {o_b_stall, o_b_ack}, 2'b10);
        tick(); b_cyc = 0; mem_drop = 0;
        tick();
        @(negedge clk);
        check("abort_release_grant", o_grant, 2'b00);
        check("wd_err_count", b_err_n - e0, 1);

        // reset in the middle of an A cycle with two outstanding
        tick();
        manual_req = manual_done;
        mem_manual = 1;
        a_cyc = 1;
        exp_req_q.push_back(req(0, 4'hF, 32'h500, 0));
        exp_req_q.push_back(req(0, 4'hF, 32'h504, 0));
        issue_a(0, 4'hF, 32'h500, 0);
        issue_a(0, 4'hF, 32'h504, 0);
        rst = 1;
        @(negedge clk);
        check("rst_mid_wb_cyc", o_wb_cyc, 0);
        check("rst_mid_grant", o_grant, 2'b00);
        check("rst_mid_a_stall", o_a_stall, 1);
        tick(); rst = 0; a_cyc = 0;
        @(negedge clk);
        check("post_rst_mid_grant", o_grant, 2'b00);
        check("post_rst_mid_wb_cyc", o_wb_cyc, 0);
        a0 = a_ack_n;
        tick();
        manual_req = manual_req + 2;
        repeat (5) tick();
        check("stray_acks_sent", pend_q.size(), 0);
        check("stray_ack_dropped", a_ack_n - a0, 0);
        mem_manual = 0;

        // leftovers
        check("exp_req_empty", exp_req_q.size(), 0);
        check("exp_a_empty", exp_a_q.size(), 0);
        check("exp_b_empty", exp_b_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
